bpb_resolve_queue: RTL
======================

BPB_RESOLVE_QUEUE -- requirements
Module: bpb_resolve_queue

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default `BPB_T, predictor table index width.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 2, log2 of queue depth (DEPTH = 2**DEPTH_WIDTH).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port push_en_i  input  1  fetch stage records a predicted branch.
REQ-006 SHALL have port push_index_i  input  INDEX_WIDTH  predictor index used at fetch.
REQ-007 SHALL have port push_pred_i  input  2  2-bit counter value read at fetch.
REQ-008 SHALL have port resolve_en_i  input  1  execute stage resolves the oldest branch.
REQ-009 SHALL have port resolve_taken_i  input  1  actual outcome of the resolved branch.
REQ-010 SHALL have port flush_i  input  1  external pipeline flush.
REQ-011 SHALL have port full_o  output  1  queue holds DEPTH entries.
REQ-012 SHALL have port empty_o  output  1  queue holds no entries.
REQ-013 SHALL have port count_o  output  DEPTH_WIDTH+1  current occupancy.
REQ-014 SHALL have port upd_valid_o  output  1  one-cycle predictor update strobe.
REQ-015 SHALL have port upd_index_o  output  INDEX_WIDTH  index to update.
REQ-016 SHALL have port upd_taken_o  output  1  outcome to train with.
REQ-017 SHALL have port mispredict_o  output  1  registered; prediction bit 1 differed from outcome.

Function
REQ-018 SHALL store pushed entries {index, pred} in FIFO order; resolve always consumes the head.
REQ-019 SHALL register the update: resolve in cycle N gives upd_valid_o=1 with head index/outcome in cycle N+1, otherwise upd_valid_o=0.
REQ-020 SHALL assert mispredict_o in N+1 iff head pred[1] != resolve_taken_i; only while upd_valid_o=1.
REQ-021 SHALL, on mispredict, discard all entries younger than the head in the same edge (count becomes 0).
REQ-022 SHALL drop a push arriving in the same cycle as a mispredicting resolve.
REQ-023 SHALL accept simultaneous push and correct resolve; count unchanged, pushed entry appended at tail.
REQ-024 SHALL ignore push when full_o=1 and resolve_en_i=0; push when full with resolve accepted in same cycle.
REQ-025 SHALL ignore resolve when empty_o=1; no update strobe, no state change.
REQ-026 SHALL, on flush_i, clear all entries and suppress push/resolve that cycle; upd_valid_o=0 next cycle.
REQ-027 SHALL wrap read/write pointers modulo DEPTH; full/empty derived from count, not pointer equality.
REQ-028 SHALL derive full_o, empty_o, count_o combinationally from registered count.

Reset
REQ-029 SHALL on rst_i clear pointers and count; empty_o=1, full_o=0, count_o=0, upd_valid_o=0, upd_index_o=0, upd_taken_o=0, mispredict_o=0.
REQ-030 SHALL discard in-flight entries on reset mid-operation; no update strobe after release until a new resolve.
REQ-031 SHALL not reset storage contents; unread entries are never observable.

Configuration
REQ-032 SHALL, with BPB_STATS_EN defined, add outputs stat_total_o[31:0] and stat_miss_o[31:0] counting accepted resolves and mispredicts, wrap at 2**32, reset to 0, unaffected by flush_i.
REQ-033 SHALL, without BPB_STATS_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-034 SHALL define in package bpb_pkg: typedef rq_entry_t {index, pred[1:0]} and localparam for the taken threshold bit.
REQ-035 SHALL use one sub-module bpb_rq_mem: DEPTH x rq_entry_t register array, one write port, one async read port.
REQ-036 SHALL connect upd_valid_o/upd_taken_o/upd_index_o directly to the local predictor's update enable, outcome and index inputs.

Verification
REQ-037 SHALL cover: push idx 5 pred 2'b10, resolve taken=1 -> next cycle upd_valid_o=1, upd_index_o=5, upd_taken_o=1, mispredict_o=0.
REQ-038 SHALL cover: fill 4 (DEPTH=4), 5th push -> full_o=1, count_o=4, 5th entry lost; four resolves return idx in push order.
REQ-039 SHALL cover: 3 entries, head pred 2'b11, resolve taken=0 -> mispredict_o=1, count_o=0, same-cycle push dropped.
REQ-040 SHALL cover: full queue, push+correct resolve same cycle -> count_o stays 4, new entry appears after 3 more resolves.
REQ-041 SHALL cover: resolve when empty -> upd_valid_o=0; flush_i with 2 entries -> empty_o=1 next cycle.
REQ-042 SHALL cover: rst_i pulsed mid-stream with 3 entries -> all outputs at reset values asynchronously, stats (BPB_STATS_EN) read 0.

Source files
------------

// File: rtl/bpb_pkg.sv
// Shared types for the branch resolve queue: queued entry layout and taken-bit position.
`ifndef BPB_T
`define BPB_T 10
`endif

package bpb_pkg;

  localparam int unsigned RQ_INDEX_W = `BPB_T;
  localparam int unsigned TAKEN_BIT  = 1;

  typedef struct packed {
    logic [RQ_INDEX_W-1:0] index;
    logic [1:0]            pred;
  } rq_entry_t;

endpackage

// File: rtl/bpb_rq_mem.sv
// Resolve-queue storage: DEPTH x rq_entry_t registers, one write port, one async read port.
module bpb_rq_mem
  import bpb_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [DEPTH_WIDTH-1:0] waddr_i,
  input  rq_entry_t              wdata_i,
  input  logic [DEPTH_WIDTH-1:0] raddr_i,
  output rq_entry_t              rdata_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;

  rq_entry_t mem_q [DEPTH];

  // Storage is deliberately unreset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bpb_resolve_queue.sv
// In-order queue of fetch-time predictions, drained by execute-stage resolves into predictor updates.
// Optional BPB_STATS_EN adds resolve/mispredict counters.
module bpb_resolve_queue
  import bpb_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = `BPB_T,
  parameter int unsigned DEPTH_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_en_i,
  input  logic [INDEX_WIDTH-1:0] push_index_i,
  input  logic [1:0]             push_pred_i,
  input  logic                   resolve_en_i,
  input  logic                   resolve_taken_i,
  input  logic                   flush_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH_WIDTH:0]   count_o,
  output logic                   upd_valid_o,
  output logic [INDEX_WIDTH-1:0] upd_index_o,
  output logic                   upd_taken_o,
  output logic                   mispredict_o
`ifdef BPB_STATS_EN
  ,
  output logic [31:0]            stat_total_o,
  output logic [31:0]            stat_miss_o
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_WIDTH;

  logic [DEPTH_WIDTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_WIDTH:0]   count_q;
  rq_entry_t              head;
  rq_entry_t              push_entry;
  logic                   res_acc, mis, push_acc;

  assign full_o  = (count_q == (DEPTH_WIDTH + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    push_entry       = '0;
    push_entry.index = RQ_INDEX_W'(push_index_i);
    push_entry.pred  = push_pred_i;
  end

  assign res_acc  = resolve_en_i && !empty_o && !flush_i;
  assign mis      = res_acc && (head.pred[TAKEN_BIT] != resolve_taken_i);
  assign push_acc = push_en_i && !flush_i && !mis && (!full_o || res_acc);

  bpb_rq_mem #(
    .DEPTH_WIDTH(DEPTH_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (push_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // A mispredict retires the head and collapses the tail onto the new read pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (mis) begin
      rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
      wr_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
      count_q  <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + DEPTH_WIDTH'(1);
      if (res_acc)  rd_ptr_q <= rd_ptr_q + DEPTH_WIDTH'(1);
      count_q <= count_q + (DEPTH_WIDTH + 1)'(push_acc) - (DEPTH_WIDTH + 1)'(res_acc);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      upd_valid_o  <= 1'b0;
      upd_index_o  <= '0;
      upd_taken_o  <= 1'b0;
      mispredict_o <= 1'b0;
    end else begin
      upd_valid_o  <= res_acc;
      mispredict_o <= mis;
      if (res_acc) begin
        upd_index_o <= INDEX_WIDTH'(head.index);
        upd_taken_o <= resolve_taken_i;
      end
    end
  end

`ifdef BPB_STATS_EN
  logic [31:0] stat_total_q, stat_miss_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_total_q <= '0;
      stat_miss_q  <= '0;
    end else begin
      if (res_acc) stat_total_q <= stat_total_q + 32'd1;
      if (mis)     stat_miss_q  <= stat_miss_q + 32'd1;
    end
  end

  assign stat_total_o = stat_total_q;
  assign stat_miss_o  = stat_miss_q;
`endif

endmodule
